// File: rtl/program_load_controller.sv
// Boot sequencer: holds the 4-bit core in reset, streams bytes into its 16x8 RAM load port,
// then releases the core and reports HLT. Define PROGRAM_LOAD_CHECKSUM_EN for a trailing checksum.
module program_load_controller #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_load,
   input  logic [ADDR_W:0]   load_len,
   input  logic              abort,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              input_mode,
   output logic [ADDR_W-1:0] input_address,
   output logic [DATA_W-1:0] input_program,
   output logic              cpu_reset_n,
   input  logic              cpu_hlt,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   byte_count
);

   localparam int unsigned CntW = ADDR_W + 1;
   localparam logic [CntW-1:0] DepthL = CntW'(DEPTH);
`ifdef PROGRAM_LOAD_CHECKSUM_EN
   localparam logic CsumEn = 1'b1;
`else
   localparam logic CsumEn = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StHalted} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   len_q;
   logic [CntW-1:0]   cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sum_q;
   logic              input_mode_q;
   logic [ADDR_W-1:0] input_address_q;
   logic [DATA_W-1:0] input_program_q;
   logic              cpu_reset_n_q;
   logic              done_q;
   logic              err_q;

   logic              len_ok;
   logic [CntW-1:0]   total;
   logic              accept;
   logic              data_phase;
   logic              last_byte;
   logic [DATA_W-1:0] csum_sum;
   logic              csum_ok;

   assign len_ok     = (load_len != '0) && (load_len <= DepthL);
   // With the checksum enabled the session carries one extra, unwritten byte.
   assign total      = len_q + CntW'(CsumEn);
   assign accept     = wr_valid && wr_ready;
   assign data_phase = cnt_q < len_q;
   assign last_byte  = (cnt_q + CntW'(1)) == total;
   assign csum_sum   = sum_q + wr_data;
   assign csum_ok    = (csum_sum == '0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start_load && len_ok) state_d = StLoad;
         end
         StLoad: begin
            if (abort) begin
               state_d = StIdle;
            end else if (accept && last_byte) begin
               state_d = (!CsumEn || csum_ok) ? StSettle : StIdle;
            end
         end
         StSettle: state_d = StRun;
         StRun: begin
            if (cpu_hlt) state_d = StHalted;
         end
         StHalted: begin
            if (start_load && len_ok) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      wr_ready      = (state_q == StLoad) && (cnt_q < total);
      busy          = (state_q == StLoad) || (state_q == StSettle);
      input_mode    = input_mode_q;
      input_address = input_address_q;
      input_program = input_program_q;
      cpu_reset_n   = cpu_reset_n_q;
      done          = done_q;
      err           = err_q;
      byte_count    = cnt_q;
   end

   // Session datapath and registered port outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q           <= '0;
         cnt_q           <= '0;
         addr_q          <= '0;
         sum_q           <= '0;
         input_mode_q    <= 1'b0;
         input_address_q <= '0;
         input_program_q <= '0;
         cpu_reset_n_q   <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            StIdle, StHalted: begin
               if (start_load) begin
                  if (len_ok) begin
                     len_q         <= load_len;
                     cnt_q         <= '0;
                     addr_q        <= '0;
                     sum_q         <= '0;
                     cpu_reset_n_q <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (abort) begin
                  input_mode_q <= 1'b0;
                  err_q        <= 1'b1;
               end else if (accept) begin
                  cnt_q <= cnt_q + CntW'(1);
                  if (data_phase) begin
                     input_address_q <= addr_q;
                     input_program_q <= wr_data;
                     addr_q          <= addr_q + ADDR_W'(1);
                     sum_q           <= csum_sum;
                     input_mode_q    <= 1'b1;
                  end else begin
                     // Checksum byte: keep the last word enabled into SETTLE only on a match.
                     input_mode_q <= csum_ok;
                     err_q        <= !csum_ok;
                  end
               end else if (!data_phase) begin
                  input_mode_q <= 1'b0;
               end
            end
            StSettle: begin
               input_mode_q  <= 1'b0;
               cpu_reset_n_q <= 1'b1;
            end
            StRun: begin
               if (cpu_hlt) done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_load_controller.sv
// Directed bench for program_load_controller with a shadow RAM fed from the load port.
module tb_program_load_controller;

`ifdef PROGRAM_LOAD_CHECKSUM_EN
   localparam int Cs = 1;
`else
   localparam int Cs = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start_load;
   logic [4:0] load_len;
   logic       abort;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       input_mode;
   logic [3:0] input_address;
   logic [7:0] input_program;
   logic       cpu_reset_n;
   logic       cpu_hlt;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] byte_count;

   int n_tests = 0;
   int n_fail  = 0;
   int hi_writes = 0;
   logic [7:0] ram [16] = '{default: 8'hEE};
   logic [7:0] prog [16];

   program_load_controller dut (
      .clk           (clk),
      .reset         (reset),
      .start_load    (start_load),
      .load_len      (load_len),
      .abort         (abort),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .input_mode    (input_mode),
      .input_address (input_address),
      .input_program (input_program),
      .cpu_reset_n   (cpu_reset_n),
      .cpu_hlt       (cpu_hlt),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .byte_count    (byte_count)
   );

   always #5 clk = ~clk;

   // Shadow of the 16x8 RAM behind the load port
   always @(posedge clk) begin
      if (input_mode) begin
         ram[input_address] <= input_program;
         if (input_address >= 4'd4) hi_writes++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [4:0] len);
      start_load = 1'b1;
      load_len   = len;
      tick();
      start_load = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int waited;
      wr_valid = 1'b0;
      repeat (gap) tick();
      wr_data  = b;
      wr_valid = 1'b1;
      waited   = 0;
      while (!wr_ready && waited < 16) begin
         tick();
         waited++;
      end
      if (!wr_ready) check("send_ready", wr_ready, 1);
      else tick();
      wr_valid = 1'b0;
   endtask

   task automatic load_prog(input int n, input int max_gap);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
         send(prog[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
         s = s + prog[i];
      end
`ifdef PROGRAM_LOAD_CHECKSUM_EN
      send(8'h00 - s, 0);
`endif
   endtask

   task automatic halt_core();
      cpu_hlt = 1'b1;
      tick();
      check("halt_done", done, 1);
      cpu_hlt = 1'b0;
      tick();
      check("halt_pulse", done, 0);
      check("halt_rstn", cpu_reset_n, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start_load = 1'b0; load_len = '0; abort = 1'b0;
      wr_valid = 1'b0; wr_data = '0; cpu_hlt = 1'b0;
      #3;
      check("rst_mode", input_mode, 0);
      check("rst_ready", wr_ready, 0);
      check("rst_rstn", cpu_reset_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done_err", {done, err}, 0);
      check("rst_count", byte_count, 0);
      @(negedge clk) reset = 1'b1;
      tick();

      // Rejected lengths from IDLE
      start(5'd0);
      check("rej0_err", err, 1);
      check("rej0_ready", wr_ready, 0);
      check("rej0_rstn", cpu_reset_n, 0);
      tick();
      check("rej0_pulse", err, 0);
      start(5'd17);
      check("rej17_err", err, 1);
      check("rej17_busy", busy, 0);
      tick();
      check("rej17_ready", wr_ready, 0);

      // Back-to-back load of four bytes
      prog[0] = 8'h79; prog[1] = 8'h30; prog[2] = 8'h7A; prog[3] = 8'h20;
      start(5'd4);
      check("l1_ready_lat", wr_ready, 1);
      check("l1_busy", busy, 1);
      check("l1_count0", byte_count, 0);
      load_prog(4, 0);
      check("l1_settle_mode", input_mode, 1);
      check("l1_settle_ready", wr_ready, 0);
      check("l1_settle_rstn", cpu_reset_n, 0);
      tick();
      check("l1_run_mode", input_mode, 0);
      check("l1_run_rstn", cpu_reset_n, 1);
      check("l1_run_busy", busy, 0);
      check("l1_count", byte_count, 4 + Cs);
      for (int i = 0; i < 4; i++) check($sformatf("l1_ram%0d", i), ram[i], prog[i]);
      halt_core();

      // Same program with random source gaps, started from HALTED
      start(5'd4);
      check("l2_rstn_drop", cpu_reset_n, 0);
      load_prog(4, 3);
      tick();
      check("l2_run_rstn", cpu_reset_n, 1);
      check("l2_count", byte_count, 4 + Cs);
      check("l2_hi_writes", hi_writes, 0);
      for (int i = 0; i < 4; i++) check($sformatf("l2_ram%0d", i), ram[i], prog[i]);
      halt_core();

      // Full-depth load 0x00..0x0F
      for (int i = 0; i < 16; i++) prog[i] = 8'(i);
      start(5'd16);
      check("l3_rstn_drop", cpu_reset_n, 0);
      load_prog(16, 0);
      check("l3_settle_addr", input_address, 15);
      tick();
      check("l3_run_rstn", cpu_reset_n, 1);
      check("l3_run_busy", busy, 0);
      check("l3_count", byte_count, 16 + Cs);
      for (int i = 0; i < 16; i++) check($sformatf("l3_ram%0d", i), ram[i], i);
      halt_core();

      // Abort after two bytes with a simultaneous accept offered
      start(5'd4);
      send(8'h11, 0);
      send(8'h22, 0);
      wr_data = 8'hAA; wr_valid = 1'b1; abort = 1'b1;
      tick();
      wr_valid = 1'b0; abort = 1'b0;
      check("ab_err", err, 1);
      check("ab_busy", busy, 0);
      check("ab_count", byte_count, 2);
      check("ab_mode", input_mode, 0);
      check("ab_rstn", cpu_reset_n, 0);
      tick();
      check("ab_ready", wr_ready, 0);
      check("ab_ram0", ram[0], 8'h11);
      check("ab_ram1", ram[1], 8'h22);
      check("ab_ram2", ram[2], 8'h02);

      // Asynchronous reset in the middle of a load
      start(5'd4);
      send(8'h31, 0);
      send(8'h32, 0);
      wr_data = 8'h33; wr_valid = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("mr_mode", input_mode, 0);
      check("mr_ready", wr_ready, 0);
      check("mr_busy", busy, 0);
      check("mr_count", byte_count, 0);
      check("mr_addr", input_address, 0);
      wr_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      tick();

`ifdef PROGRAM_LOAD_CHECKSUM_EN
      // Bad checksum, then a good one
      start(5'd2);
      send(8'h01, 0);
      send(8'h03, 0);
      send(8'hFD, 0);
      check("cs_bad_err", err, 1);
      check("cs_bad_busy", busy, 0);
      check("cs_bad_rstn", cpu_reset_n, 0);
      check("cs_bad_mode", input_mode, 0);
      prog[0] = 8'h01; prog[1] = 8'h03;
      start(5'd2);
      load_prog(2, 0);
      check("cs_ok_busy", busy, 1);
      tick();
      check("cs_ok_rstn", cpu_reset_n, 1);
      check("cs_ok_count", byte_count, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
